// File: rtl/regfile_wb_queue_if.sv
// Writeback queue bus: ALU and load result handshakes, register file write
// port, decode source lookup and queue occupancy.
// Optional macro WB_BYPASS_EN adds the forwarding outputs.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_w_data;
    logic          reg_write;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic [CW-1:0] count;
`ifdef WB_BYPASS_EN
    logic          rs_fwd_valid;
    logic [DW-1:0] rs_fwd_data;
    logic          rt_fwd_valid;
    logic [DW-1:0] rt_fwd_data;
`endif

    // Producer / decode / register-file side
    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output rs_addr, rt_addr,
        input  alu_ready, ld_ready,
        input  rd_addr, rd_w_data, reg_write,
        input  rs_busy, rt_busy, count
`ifdef WB_BYPASS_EN
        , input rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data
`endif
    );

    // Queue side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  rs_addr, rt_addr,
        output alu_ready, ld_ready,
        output rd_addr, rd_w_data, reg_write,
        output rs_busy, rt_busy, count
`ifdef WB_BYPASS_EN
        , output rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data
`endif
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file write port.
// Load results win over ALU results; address 0 results are acknowledged
// and dropped. The head retires every cycle the queue is nonempty.
// Optional macro WB_BYPASS_EN adds youngest-match forwarding data.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic          full;
    logic          ld_acc;
    logic          alu_acc;
    logic          push;
    logic          pop;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          rs_hit;
    logic          rt_hit;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [PW-1:0] idx;

    // Readiness depends only on registered occupancy, never on the same-cycle pop
    assign full          = (count_q == CW'(DEPTH));
    assign bus.ld_ready  = !full;
    assign bus.alu_ready = !full && !bus.ld_valid;
    assign ld_acc        = bus.ld_valid && !full;
    assign alu_acc       = bus.alu_valid && !full && !bus.ld_valid;
    assign in_addr       = ld_acc ? bus.ld_addr : bus.alu_addr;
    assign in_data       = ld_acc ? bus.ld_data : bus.alu_data;
    assign push          = (ld_acc || alu_acc) && (in_addr != '0);
    assign pop           = (count_q != '0);

    assign bus.reg_write = pop;
    assign bus.rd_addr   = pop ? addr_mem[rd_ptr] : '0;
    assign bus.rd_w_data = pop ? data_mem[rd_ptr] : '0;
    assign bus.count     = count_q;

    // Scan occupied entries oldest to youngest so the last hit is the youngest
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_data = '0;
        rt_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count_q) begin
                if ((bus.rs_addr != '0) && (addr_mem[idx] == bus.rs_addr)) begin
                    rs_hit  = 1'b1;
                    rs_data = data_mem[idx];
                end
                if ((bus.rt_addr != '0) && (addr_mem[idx] == bus.rt_addr)) begin
                    rt_hit  = 1'b1;
                    rt_data = data_mem[idx];
                end
            end
        end
    end

    assign bus.rs_busy = rs_hit;
    assign bus.rt_busy = rt_hit;

`ifdef WB_BYPASS_EN
    assign bus.rs_fwd_valid = rs_hit;
    assign bus.rs_fwd_data  = rs_data;
    assign bus.rt_fwd_valid = rt_hit;
    assign bus.rt_fwd_data  = rt_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_data, rt_data};
`endif

    // Entry storage; stale contents are harmless because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; reset drops every queued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed steps followed by
// random traffic, compared against a queue-based reference model.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();
    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] model_rf [32];
    logic [DW-1:0] dut_rf   [32];
    int            total  = 0;
    int            passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic cycle();
        bit            full;
        bit            acc;
        logic [AW-1:0] acc_a;
        logic [DW-1:0] acc_d;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_rs, e_rt;
        logic [DW-1:0] e_rsd, e_rtd;
        #1;
        full   = (q.size() >= DEPTH);
        e_addr = '0;
        e_data = '0;
        if (q.size() > 0) begin
            e_addr = q[0].a;
            e_data = q[0].d;
        end
        e_rs = 1'b0; e_rt = 1'b0; e_rsd = '0; e_rtd = '0;
        foreach (q[i]) begin
            if (bus.rs_addr != 0 && q[i].a == bus.rs_addr) begin e_rs = 1'b1; e_rsd = q[i].d; end
            if (bus.rt_addr != 0 && q[i].a == bus.rt_addr) begin e_rt = 1'b1; e_rtd = q[i].d; end
        end
        chk("count",     bus.count,     q.size());
        chk("reg_write", bus.reg_write, q.size() != 0);
        chk("rd_addr",   bus.rd_addr,   e_addr);
        chk("rd_w_data", bus.rd_w_data, e_data);
        chk("ld_ready",  bus.ld_ready,  !full);
        chk("alu_ready", bus.alu_ready, !full && !bus.ld_valid);
        chk("rs_busy",   bus.rs_busy,   e_rs);
        chk("rt_busy",   bus.rt_busy,   e_rt);
`ifdef WB_BYPASS_EN
        chk("rs_fwd_valid", bus.rs_fwd_valid, e_rs);
        chk("rs_fwd_data",  bus.rs_fwd_data,  e_rsd);
        chk("rt_fwd_valid", bus.rt_fwd_valid, e_rt);
        chk("rt_fwd_data",  bus.rt_fwd_data,  e_rtd);
`endif
        if (bus.reg_write === 1'b1) dut_rf[bus.rd_addr] = bus.rd_w_data;
        acc   = !full && (bus.ld_valid || bus.alu_valid);
        acc_a = bus.ld_valid ? bus.ld_addr : bus.alu_addr;
        acc_d = bus.ld_valid ? bus.ld_data : bus.alu_data;
        @(posedge clk);
        if (q.size() > 0) begin
            model_rf[q[0].a] = q[0].d;
        end
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc && acc_a != 0) q.push_back('{a: acc_a, d: acc_d});
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd3; bus.ld_data = 32'hA5A5_0003;
        bus.rs_addr   = '0;   bus.rt_addr  = '0;

        // Reset held for two edges with a load pending
        @(posedge clk);
        @(negedge clk);
        cycle();
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_alu_ready", bus.alu_ready, 0);

        // First push after release
        rst = 1'b0;
        cycle();
        #1;
        chk("post_rst_write", bus.reg_write, 1);
        chk("post_rst_addr", bus.rd_addr, 3);

        // Single ALU write
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        bus.rs_addr   = 5'd5;
        cycle();
        bus.alu_valid = 1'b0;
        #1;
        chk("single_write", bus.reg_write, 1);
        chk("single_addr", bus.rd_addr, 5);
        chk("single_data", bus.rd_w_data, 32'hDEAD_BEEF);
        chk("single_busy", bus.rs_busy, 1);
        cycle();
        #1;
        chk("single_drained", bus.count, 0);

        // Load priority over ALU, in-order retirement
        for (int i = 1; i <= 4; i++) begin
            bus.ld_valid  = 1'b1; bus.ld_addr = AW'(i); bus.ld_data = 32'h100 + i;
            bus.alu_valid = 1'b1; bus.alu_addr = 5'd9;  bus.alu_data = 32'h99;
            #1;
            chk("prio_alu_ready", bus.alu_ready, 0);
            cycle();
            #1;
            chk("prio_order", bus.rd_addr, i);
        end
        bus.ld_valid = 1'b0;
        #1;
        chk("prio_alu_released", bus.alu_ready, 1);
        cycle();
        bus.alu_valid = 1'b0;
        #1;
        chk("prio_alu_retire", bus.rd_addr, 9);
        cycle();

        // Address zero is acknowledged and dropped
        bus.alu_valid = 1'b1; bus.alu_addr = '0; bus.alu_data = 32'h1234;
        bus.rs_addr   = '0;
        cycle();
        bus.alu_valid = 1'b0;
        #1;
        chk("zero_write", bus.reg_write, 0);
        chk("zero_count", bus.count, 0);
        chk("zero_busy", bus.rs_busy, 0);

`ifdef WB_BYPASS_EN
        // Youngest matching entry forwards
        bus.rs_addr  = 5'd7;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h11;
        cycle();
        bus.ld_data = 32'h22;
        #1;
        chk("byp_first", bus.rs_fwd_data, 32'h11);
        cycle();
        bus.ld_valid = 1'b0;
        #1;
        chk("byp_valid", bus.rs_fwd_valid, 1);
        chk("byp_young", bus.rs_fwd_data, 32'h22);
        cycle();
        #1;
        chk("byp_gone", bus.rs_fwd_valid, 0);
`endif

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            bus.ld_valid  = ($urandom_range(0, 99) < 40);
            bus.alu_valid = ($urandom_range(0, 99) < 50);
            bus.ld_addr   = AW'($urandom_range(0, 7));
            bus.alu_addr  = AW'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.alu_data  = $urandom;
            bus.rs_addr   = AW'($urandom_range(0, 7));
            bus.rt_addr   = AW'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0;
        bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
        cycle();
        cycle();

        // Register file contents reflect ordered retirement
        for (int r = 0; r < 32; r++) chk("regfile", dut_rf[r], model_rf[r]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
